// File: rtl/somador_serial_ctrl_if.sv
// Operand/result bundle for the bit-serial adder controller.
// SOMADOR_SERIAL_SUB_EN adds the subtrai request bit.
interface somador_serial_ctrl_if #(
  parameter int N = 8
);
  logic         inicio;
  logic [N-1:0] opA;
  logic [N-1:0] opB;
`ifdef SOMADOR_SERIAL_SUB_EN
  logic         subtrai;
`endif
  logic         ocupado;
  logic         pronto;
  logic [N-1:0] resultado;
  logic         tSaida;

`ifdef SOMADOR_SERIAL_SUB_EN
  modport master (output inicio, opA, opB, subtrai,
                  input  ocupado, pronto, resultado, tSaida);
  modport slave  (input  inicio, opA, opB, subtrai,
                  output ocupado, pronto, resultado, tSaida);
`else
  modport master (output inicio, opA, opB,
                  input  ocupado, pronto, resultado, tSaida);
  modport slave  (input  inicio, opA, opB,
                  output ocupado, pronto, resultado, tSaida);
`endif
endinterface

// File: rtl/somador_serial_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell, carry recirculated, LSB first.
// SOMADOR_SERIAL_SUB_EN enables two's-complement subtraction via subtrai.
module SomadorUmBit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module somador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  somador_serial_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SOMA, FIM} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  op_a_reg, op_b_reg, resultado_reg;
  logic          carry_reg, tsaida_reg;
  logic [CW-1:0] cnt_reg;
  logic          soma_bit, carry_out, last_bit;
  logic [N-1:0]  op_b_load;
  logic          cin_load;

`ifdef SOMADOR_SERIAL_SUB_EN
  // a - b = a + ~b + 1
  assign op_b_load = bus.subtrai ? ~bus.opB : bus.opB;
  assign cin_load  = bus.subtrai;
`else
  assign op_b_load = bus.opB;
  assign cin_load  = 1'b0;
`endif

  SomadorUmBit u_fa (
    .a    (op_a_reg[0]),
    .b    (op_b_reg[0]),
    .cin  (carry_reg),
    .s    (soma_bit),
    .cout (carry_out)
  );

  assign last_bit = (cnt_reg == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.inicio) state_next = SOMA;
      SOMA:    if (last_bit)   state_next = FIM;
      FIM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      resultado_reg <= '0;
      carry_reg     <= 1'b0;
      tsaida_reg    <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.inicio) begin
            op_a_reg  <= bus.opA;
            op_b_reg  <= op_b_load;
            carry_reg <= cin_load;
            cnt_reg   <= '0;
          end
        end
        SOMA: begin
          op_a_reg      <= {1'b0, op_a_reg[N-1:1]};
          op_b_reg      <= {1'b0, op_b_reg[N-1:1]};
          resultado_reg <= {soma_bit, resultado_reg[N-1:1]};
          carry_reg     <= carry_out;
          cnt_reg       <= cnt_reg + 1'b1;
          // Capture carry-out on the last bit so it is valid alongside pronto.
          if (last_bit) tsaida_reg <= carry_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.ocupado   = (state_reg != IDLE);
  assign bus.pronto    = (state_reg == FIM);
  assign bus.resultado = resultado_reg;
  assign bus.tSaida    = tsaida_reg;
endmodule
